// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues word reads on the instruction bus,
// buffers returned words toward decode and restarts cleanly on a control redirect.
module fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter int          FIFO_SLOTS   = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,

    output logic        ibus_req_valid_o,
    output logic [31:0] ibus_req_addr_o,
    input  logic        ibus_req_ready_i,
    input  logic        ibus_rsp_valid_i,
    input  logic [31:0] ibus_rsp_data_i,
    input  logic        ibus_rsp_err_i,
    output logic        ibus_rsp_ready_o,

    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_err_o,
    input  logic        instr_ready_i
);

    localparam int CW = $clog2(FIFO_SLOTS + 1);
    localparam int PW = $clog2(FIFO_SLOTS);

    // Program counter and request channel
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          req_pend_q, req_pend_d;
    logic          kill_pend_q, kill_pend_d;

    // Credit and stale-response bookkeeping
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] discard_cnt_q, discard_cnt_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;

    // Instruction buffer
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [31:0]   fifo_data_q [FIFO_SLOTS];
    logic [31:0]   fifo_pc_q   [FIFO_SLOTS];
    logic          fifo_err_q  [FIFO_SLOTS];

    logic          flush;
    logic [31:0]   target;
    logic          req_acc;
    logic          rsp_acc;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic          launch;
    logic          fifo_nonempty;
    logic [CW:0]   credit_used;

    always_comb begin
        flush         = fetch_req_i;
        target        = fetch_addr_i & 32'hFFFF_FFFC;
        req_acc       = req_pend_q && ibus_req_ready_i;
        rsp_acc       = ibus_rsp_valid_i;
        fifo_nonempty = (fifo_cnt_q != '0);
        credit_used   = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
        // Credit is judged on registered counts only, so a pop this cycle frees nothing yet.
        launch        = !req_pend_q && !flush && (credit_used < (CW+1)'(FIFO_SLOTS));
        rsp_drop      = rsp_acc && (discard_cnt_q != '0);
        push          = rsp_acc && !rsp_drop && !flush;
        pop           = fifo_nonempty && instr_ready_i && !flush;
    end

    always_comb begin
        out_cnt_d = out_cnt_q + CW'(req_acc) - CW'(rsp_acc);

        req_pend_d = req_pend_q;
        req_addr_d = req_addr_q;
        if (launch) begin
            req_pend_d = 1'b1;
            req_addr_d = pc_q;
        end else if (req_acc) begin
            req_pend_d = 1'b0;
        end

        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        if (flush) begin
            pc_d     = target;
            rsp_pc_d = target;
        end else begin
            if (launch) pc_d = pc_q + 32'd4;
            if (push)   rsp_pc_d = rsp_pc_q + 32'd4;
        end

        // On redirect everything already on the bus, plus a request accepted now, is stale;
        // a request still waiting for acceptance is marked and counted once it goes out.
        if (flush) begin
            discard_cnt_d = out_cnt_d;
            kill_pend_d   = req_pend_q && !ibus_req_ready_i;
        end else begin
            discard_cnt_d = discard_cnt_q - CW'(rsp_drop) + CW'(req_acc && kill_pend_q);
            kill_pend_d   = req_acc ? 1'b0 : kill_pend_q;
        end

        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            rd_ptr_d   = rd_ptr_q + PW'(pop);
            wr_ptr_d   = wr_ptr_q + PW'(push);
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            req_addr_q    <= RESET_VECTOR;
            req_pend_q    <= 1'b0;
            kill_pend_q   <= 1'b0;
            out_cnt_q     <= '0;
            discard_cnt_q <= '0;
            rsp_pc_q      <= RESET_VECTOR;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            req_pend_q    <= req_pend_d;
            kill_pend_q   <= kill_pend_d;
            out_cnt_q     <= out_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            rsp_pc_q      <= rsp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: every read of it is qualified by the entry count.
    for (genvar gi = 0; gi < FIFO_SLOTS; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PW'(gi))) begin
                fifo_data_q[gi] <= ibus_rsp_data_i;
                fifo_pc_q[gi]   <= rsp_pc_q;
                fifo_err_q[gi]  <= ibus_rsp_err_i;
            end
        end
    end

    always_comb begin
        ibus_req_valid_o = req_pend_q;
        ibus_req_addr_o  = req_addr_q;
        ibus_rsp_ready_o = 1'b1;
        instr_valid_o    = fifo_nonempty;
        instr_o          = fifo_nonempty ? fifo_data_q[rd_ptr_q] : 32'd0;
        instr_pc_o       = fifo_nonempty ? fifo_pc_q[rd_ptr_q]   : 32'd0;
        instr_err_o      = fifo_nonempty ? fifo_err_q[rd_ptr_q]  : 1'b0;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_cnt_q == CW'(FIFO_SLOTS))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(rsp_acc && (out_cnt_q == '0)));

endmodule

// File: tb/tb_fetch.sv
// Randomised bench for fetch: a bus slave model feeds responses, a queue of expected
// instruction addresses (sequential from reset or each redirect) is checked at decode.
module tb_fetch;

    localparam logic [31:0] RV    = 32'h8000_0000;
    localparam int          SLOTS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req_i = 1'b0;
    logic [31:0] fetch_addr_i = '0;
    logic        ibus_req_valid_o;
    logic [31:0] ibus_req_addr_o;
    logic        ibus_req_ready_i = 1'b0;
    logic        ibus_rsp_valid_i = 1'b0;
    logic [31:0] ibus_rsp_data_i = '0;
    logic        ibus_rsp_err_i = 1'b0;
    logic        ibus_rsp_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_err_o;
    logic        instr_ready_i = 1'b0;

    fetch #(.RESET_VECTOR(RV), .FIFO_SLOTS(SLOTS)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
        .ibus_req_valid_o(ibus_req_valid_o), .ibus_req_addr_o(ibus_req_addr_o),
        .ibus_req_ready_i(ibus_req_ready_i),
        .ibus_rsp_valid_i(ibus_rsp_valid_i), .ibus_rsp_data_i(ibus_rsp_data_i),
        .ibus_rsp_err_i(ibus_rsp_err_i), .ibus_rsp_ready_o(ibus_rsp_ready_o),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_err_o(instr_err_o), .instr_ready_i(instr_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] next_exp = RV;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          consumed = 0;
    int          ready_pct = 0, rsp_pct = 100, lat_min = 0, lat_max = 0;
    int          instr_pct = 0, flush_pm = 0;
    bit          triple_arm = 0, triple_hit = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return a[6:2] == 5'd3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus/decode/control cycle; all inputs change on the falling edge.
    task automatic cycle(input bit flush, input logic [31:0] faddr);
        bit          rsp_now;
        bit          fl;
        logic [31:0] fa;
        bus_t        b;
        @(negedge clk);
        cyc++;
        rsp_now = (bus_q.size() > 0) && (bus_q[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
        ibus_rsp_valid_i = rsp_now;
        ibus_rsp_data_i  = rsp_now ? mem_word(bus_q[0].addr) : 32'd0;
        ibus_rsp_err_i   = rsp_now ? err_of(bus_q[0].addr) : 1'b0;
        if (rsp_now) void'(bus_q.pop_front());
        ibus_req_ready_i = ($urandom_range(99) < ready_pct);
        instr_ready_i    = ($urandom_range(99) < instr_pct);
        fl = flush;
        fa = faddr;
        if (!fl && ($urandom_range(999) < flush_pm)) begin
            fl = 1'b1;
            fa = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
        end
        if (triple_arm && ibus_req_valid_o && ibus_req_ready_i && rsp_now) begin
            fl = 1'b1;
            fa = 32'h0000_0300;
            triple_hit = 1'b1;
            triple_arm = 1'b0;
        end
        if (ibus_req_valid_o && ibus_req_ready_i) begin
            b.addr = ibus_req_addr_o;
            b.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
            bus_q.push_back(b);
            acc_log.push_back(ibus_req_addr_o);
        end
        fetch_req_i  = fl;
        fetch_addr_i = fl ? fa : $urandom();
        if (fl) begin
            exp_q.delete();
            next_exp = {fa[31:2], 2'b00};
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_exp);
            next_exp = next_exp + 32'd4;
        end
        if (fl) $display("cycle %0d: redirect to %08h", cyc, {fa[31:2], 2'b00});
    endtask

    // Monitor: bus protocol and decode-side scoreboard, sampled mid-cycle.
    initial begin
        logic        pv, pr, pf;
        logic [31:0] pa, e;
        pv = 0; pr = 0; pf = 0; pa = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pv = 0; pf = 0;
                continue;
            end
            if (pv && !pr) begin
                chk("req_hold_valid", {31'd0, ibus_req_valid_o}, 32'd1);
                chk("req_hold_addr", ibus_req_addr_o, pa);
            end
            if (pf) chk("flush_clears_valid", {31'd0, instr_valid_o}, 32'd0);
            if (ibus_req_valid_o) chk("req_aligned", {30'd0, ibus_req_addr_o[1:0]}, 32'd0);
            chk("outstanding_le_slots", {31'd0, bus_q.size() <= SLOTS}, 32'd1);
            if (instr_valid_o && instr_ready_i && !fetch_req_i) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", instr_pc_o, e);
                    chk("instr_data", instr_o, mem_word(e));
                    chk("instr_err", {31'd0, instr_err_o}, {31'd0, err_of(e)});
                    $display("cycle %0d: decode pc=%08h data=%08h err=%0d", cyc, instr_pc_o, instr_o, instr_err_o);
                end
                consumed++;
            end
            pv = ibus_req_valid_o;
            pr = ibus_req_ready_i;
            pa = ibus_req_addr_o;
            pf = fetch_req_i;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          c0;
        logic [31:0] stale;
        repeat (3) @(negedge clk);
        chk("rst_req_valid", {31'd0, ibus_req_valid_o}, 32'd0);
        chk("rst_req_addr", ibus_req_addr_o, RV);
        chk("rst_instr_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_instr_pc", instr_pc_o, 32'd0);
        chk("rst_instr_err", {31'd0, instr_err_o}, 32'd0);
        chk("rsp_ready_const", {31'd0, ibus_rsp_ready_o}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("first_req_valid", {31'd0, ibus_req_valid_o}, 32'd1);
        chk("first_req_addr", ibus_req_addr_o, RV);

        // Decode stalled on a zero-wait bus: credit allows exactly SLOTS requests.
        ready_pct = 100; rsp_pct = 100; lat_min = 0; lat_max = 0; instr_pct = 0;
        acc_log.delete();
        repeat (20) cycle(0, '0);
        chk("stall_req_count", acc_log.size(), SLOTS);
        chk("stall_req_idle", {31'd0, ibus_req_valid_o}, 32'd0);
        acc_log.delete();
        instr_pct = 100;
        for (int i = 0; i < 20 && acc_log.size() == 0; i++) cycle(0, '0);
        if (acc_log.size() == 0) chk("resume_timeout", 32'd0, 32'd1);
        else chk("resume_addr", acc_log[0], RV + 32'd8);
        repeat (40) cycle(0, '0);

        // Redirect with two requests outstanding.
        lat_min = 6; lat_max = 6;
        for (int i = 0; i < 30 && bus_q.size() != 2; i++) cycle(0, '0);
        chk("two_outstanding", bus_q.size(), 2);
        cycle(1, 32'h0000_0100);
        c0 = consumed;
        for (int i = 0; i < 60 && consumed == c0; i++) cycle(0, '0);
        chk("after_flush_progress", {31'd0, consumed > c0}, 32'd1);

        // Redirect while a request is held off by the bus.
        lat_min = 1; lat_max = 1; ready_pct = 0;
        for (int i = 0; i < 20 && !ibus_req_valid_o; i++) cycle(0, '0);
        stale = ibus_req_addr_o;
        acc_log.delete();
        cycle(1, 32'h0000_0200);
        repeat (3) cycle(0, '0);
        chk("stale_still_held", ibus_req_addr_o, stale);
        ready_pct = 100;
        for (int i = 0; i < 40 && acc_log.size() < 2; i++) cycle(0, '0);
        if (acc_log.size() < 2) chk("redirect_req_timeout", acc_log.size(), 2);
        else begin
            chk("stale_accepted_first", acc_log[0], stale);
            chk("redirect_req_addr", acc_log[1], 32'h0000_0200);
        end
        repeat (20) cycle(0, '0);

        // Redirect, response and request acceptance in one cycle.
        triple_arm = 1;
        for (int i = 0; i < 40 && !triple_hit; i++) cycle(0, '0);
        chk("triple_event_hit", {31'd0, triple_hit}, 32'd1);
        triple_arm = 0;
        c0 = consumed;
        for (int i = 0; i < 60 && consumed == c0; i++) cycle(0, '0);
        chk("after_triple_progress", {31'd0, consumed > c0}, 32'd1);

        // PC wrap around the top of the address space.
        cycle(1, 32'hFFFF_FFF9);
        repeat (30) cycle(0, '0);

        // Randomised traffic with random redirects.
        for (int blk = 0; blk < 15; blk++) begin
            ready_pct = $urandom_range(100, 30);
            rsp_pct   = $urandom_range(100, 30);
            lat_min   = $urandom_range(2);
            lat_max   = lat_min + $urandom_range(4);
            instr_pct = $urandom_range(100, 20);
            flush_pm  = $urandom_range(40);
            repeat (200) cycle(0, '0);
        end

        flush_pm = 0; ready_pct = 100; rsp_pct = 100; instr_pct = 100; lat_min = 0; lat_max = 2;
        c0 = consumed;
        repeat (50) cycle(0, '0);
        chk("drain_progress", {31'd0, consumed > c0}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
